// File: rtl/ram_master_16x8_pkg.sv
// Shared constants for the 16x8 RAM master and its RAM: geometry and FSM state encodings.
package ram_master_16x8_pkg;

    localparam int unsigned RAM_ADDR_WIDTH = 4;
    localparam int unsigned RAM_DATA_WIDTH = 8;
    localparam int unsigned RAM_DEPTH      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_master_16x8_if.sv
// Host-side command, write-beat and read-beat handshake bundle for the RAM master.
interface ram_master_16x8_if import ram_master_16x8_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  done;

    // Host side
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done
    );

    // Burst engine side
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, done
    );

endinterface

// File: rtl/ram_master_16x8.sv
// Burst engine between a host handshake bus and a single-port RAM with a shared
// bidirectional data bus; bursts wrap modulo DEPTH.
module ram_master_16x8 import ram_master_16x8_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int unsigned DEPTH      = RAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_master_16x8_if.slave      host,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_inc;

    assign addr_inc = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    // Next-state: one beat per handshake (write) or per cycle (read); last beat enters DONE.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (host.cmd_valid) begin
                    addr_d  = host.cmd_addr;
                    count_d = host.cmd_len;
                    state_d = host.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (host.wr_valid) begin
                    addr_d  = addr_inc;
                    count_d = count_q - ADDR_WIDTH'(1);
                    if (count_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                    end
                end
            end
            READ: begin
                rd_data_d  = ram_data;
                rd_valid_d = 1'b1;
                addr_d     = addr_inc;
                count_d    = count_q - ADDR_WIDTH'(1);
                if (count_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    addr_d  = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM-side controls are combinational so a write lands on the same edge as its handshake.
    assign host.cmd_ready = (state_q == IDLE) && !rst;
    assign host.wr_ready  = (state_q == WRITE) && !rst;
    assign ram_we         = host.wr_ready && host.wr_valid;
    assign ram_addr       = ((state_q == WRITE) || (state_q == READ)) ? addr_q : '0;
    assign ram_data       = ram_we ? host.wr_data : {DATA_WIDTH{1'bz}};

    assign host.rd_data  = rd_data_q;
    assign host.rd_valid = rd_valid_q;
    assign host.done     = done_q;

endmodule

// File: tb/tb_ram_master_16x8.sv
// Directed bench: RAM master paired with an async-read / sync-write 16x8 RAM model on a shared bus.
module tb_ram_master_16x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ram_we;
    logic [3:0] ram_addr;
    wire  [7:0] ram_data;

    ram_master_16x8_if bus ();

    ram_master_16x8 dut (
        .clk      (clk),
        .rst      (rst),
        .host     (bus),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    // sync_ram_16X8 behaviour: drives the bus whenever ram_we=0, writes on the rising edge.
    logic [7:0] mem [16];
    int nwrites = 0;
    int ndone   = 0;
    assign ram_data = ram_we ? 8'bz : mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_data;
            nwrites       <= nwrites + 1;
        end
        if (bus.done) ndone <= ndone + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic             wr;
        logic [3:0]       addr;
        logic [3:0]       len;
        logic [15:0][7:0] data;
    } vec_t;

    // Issue one burst; read data expectations come from d, written beats from d too.
    task automatic run_burst(input logic wr, input logic [3:0] a, input logic [3:0] len,
                             input logic [15:0][7:0] d, input int stall);
        int n;
        n = int'(len) + 1;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = len;
        #1 check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (wr) begin
            for (int b = 0; b < n; b++) begin
                if (b == 1) begin
                    for (int s = 0; s < stall; s++) begin
                        bus.wr_valid = 1'b0;
                        #1;
                        check("stall_we", 32'(ram_we), 32'd0);
                        check("stall_wr_ready", 32'(bus.wr_ready), 32'd1);
                        check("stall_addr", 32'(ram_addr), 32'(4'(a + 4'd1)));
                        @(negedge clk);
                    end
                end
                bus.wr_valid = 1'b1; bus.wr_data = d[b];
                #1;
                check("wr_we", 32'(ram_we), 32'd1);
                check("wr_addr", 32'(ram_addr), 32'(4'(a + 4'(b))));
                check("wr_busy_cmd_ready", 32'(bus.cmd_ready), 32'd0);
                @(negedge clk);
            end
            bus.wr_valid = 1'b0;
            #1 check("wr_done", 32'(bus.done), 32'd1);
            check("wr_done_addr", 32'(ram_addr), 32'd0);
        end else begin
            for (int b = 0; b < n; b++) begin
                #1;
                check("rd_addr", 32'(ram_addr), 32'(4'(a + 4'(b))));
                check("rd_we", 32'(ram_we), 32'd0);
                check("rd_valid_beat", 32'(bus.rd_valid), 32'(b > 0));
                if (b > 0) check("rd_data", 32'(bus.rd_data), 32'(d[b-1]));
                check("rd_done_early", 32'(bus.done), 32'd0);
                @(negedge clk);
            end
            #1;
            check("rd_done", 32'(bus.done), 32'd1);
            check("rd_last_valid", 32'(bus.rd_valid), 32'd1);
            check("rd_last_data", 32'(bus.rd_data), 32'(d[n-1]));
        end
        @(negedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("rd_valid_after", 32'(bus.rd_valid), 32'd0);
        check("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    endtask

    vec_t vecs [6];

    initial begin
        int w0, d0;
        vecs[0] = '{wr: 1'b1, addr: 4'd3,  len: 4'd0,  data: 128'hA5};
        vecs[1] = '{wr: 1'b0, addr: 4'd3,  len: 4'd0,  data: 128'hA5};
        vecs[2] = '{wr: 1'b1, addr: 4'd14, len: 4'd3,  data: 128'h44332211};
        vecs[3] = '{wr: 1'b0, addr: 4'd14, len: 4'd3,  data: 128'h44332211};
        vecs[4] = '{wr: 1'b1, addr: 4'd0,  len: 4'd15, data: 128'h0F0E0D0C0B0A09080706050403020100};
        vecs[5] = '{wr: 1'b0, addr: 4'd0,  len: 4'd15, data: 128'h0F0E0D0C0B0A09080706050403020100};

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0;
        repeat (2) @(negedge clk);
        #1 check("rst_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("reset_rd_data", 32'(bus.rd_data), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_addr", 32'(ram_addr), 32'd0);

        for (int i = 0; i < 6; i++) begin
            w0 = nwrites; d0 = ndone;
            run_burst(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].data, 0);
            check("done_pulses", 32'(ndone - d0), 32'd1);
            if (vecs[i].wr) begin
                check("write_count", 32'(nwrites - w0), 32'(int'(vecs[i].len) + 1));
                for (int b = 0; b <= int'(vecs[i].len); b++)
                    check("ram_content", 32'(mem[4'(vecs[i].addr + 4'(b))]), 32'(vecs[i].data[b]));
            end else begin
                check("read_no_write", 32'(nwrites - w0), 32'd0);
            end
        end

        // Write with a three-cycle gap between the two beats, then read it back.
        w0 = nwrites;
        run_burst(1'b1, 4'd8, 4'd1, 128'hC35A, 3);
        check("stall_write_count", 32'(nwrites - w0), 32'd2);
        check("stall_mem8", 32'(mem[8]), 32'h5A);
        check("stall_mem9", 32'(mem[9]), 32'hC3);
        run_burst(1'b0, 4'd8, 4'd1, 128'hC35A, 0);

        // Reset after two of four beats; a second command held during the burst is ignored.
        w0 = nwrites; d0 = ndone;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 4'd5; bus.cmd_len = 4'd3;
        @(negedge clk);
        bus.cmd_write = 1'b0; bus.cmd_addr = 4'd9;
        bus.wr_valid = 1'b1; bus.wr_data = 8'hE1;
        #1;
        check("busy_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("abort_beat0_addr", 32'(ram_addr), 32'd5);
        @(negedge clk);
        bus.wr_data = 8'hE2;
        #1 check("abort_beat1_addr", 32'(ram_addr), 32'd6);
        @(negedge clk);
        rst = 1'b1; bus.wr_data = 8'hE3;
        #1 check("abort_rst_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst = 1'b0; bus.wr_valid = 1'b0; bus.cmd_valid = 1'b0;
        #1;
        check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_addr", 32'(ram_addr), 32'd0);
        @(negedge clk);
        #1 check("abort_still_idle", 32'(bus.cmd_ready), 32'd1);
        check("abort_write_count", 32'(nwrites - w0), 32'd2);
        check("abort_no_done", 32'(ndone - d0), 32'd0);
        check("abort_mem7", 32'(mem[7]), 32'h07);
        run_burst(1'b0, 4'd5, 4'd2, 128'h07E2E1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
